// File: rtl/clk_div_sched_pkg.sv
// Shared types and default widths for the clk_div_sched divider controller.
package clk_div_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam int CNT_W_DEF  = 8;
    localparam int EDGE_W_DEF = 16;

endpackage

// File: rtl/clk_div_sched_cnt.sv
// Half-period counter producing the divided clock level, its rising-edge strobe
// and the falling-boundary indication used to schedule reconfiguration.
module clk_div_sched_cnt
    import clk_div_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             RST,
    input  logic             run,
    input  logic [CNT_W-1:0] half,
    output logic             clk_out,
    output logic             tick,
    output logic             fall_bnd
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             at_top;

    always_comb begin
        at_top    = (cnt_q == half);
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        if (!run) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (at_top) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        tick_d   = clk_out_d & ~clk_out_q;
        fall_bnd = run & at_top & clk_out_q;
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_sched.sv
// Runtime-programmable clock divider; new settings land only on a falling boundary.
// Define CLK_DIV_SCHED_EDGE_CNT_EN to add the edge_cnt rising-edge counter port.
module clk_div_sched
    import clk_div_sched_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int EDGE_W = EDGE_W_DEF
) (
    input  logic              clk_in,
    input  logic              RST,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_en,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              clk_out,
    output logic              tick,
    output logic              busy
`ifdef CLK_DIV_SCHED_EDGE_CNT_EN
    ,
    output logic [EDGE_W-1:0] edge_cnt
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_en_q, pend_en_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             accept;
    logic             run;
    logic             fall_bnd;

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        pend_half_d = pend_half_q;
        pend_en_d   = pend_en_q;
        accept      = cfg_valid & cfg_ready_q;
        case (state_q)
            ST_IDLE: begin
                // A stop request while already stopped is simply absorbed.
                if (accept && cfg_en) begin
                    half_d  = cfg_half;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    pend_half_d = cfg_half;
                    pend_en_d   = cfg_en;
                    state_d     = ST_PEND;
                end
            end
            ST_PEND: begin
                if (fall_bnd) begin
                    if (pend_en_q) begin
                        half_d  = pend_half_q;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cfg_ready_d = (state_d != ST_PEND);
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            half_q      <= '0;
            pend_half_q <= '0;
            pend_en_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            pend_half_q <= pend_half_d;
            pend_en_q   <= pend_en_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign run       = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign cfg_ready = cfg_ready_q;

    clk_div_sched_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_in   (clk_in),
        .RST      (RST),
        .run      (run),
        .half     (half_q),
        .clk_out  (clk_out),
        .tick     (tick),
        .fall_bnd (fall_bnd)
    );

`ifdef CLK_DIV_SCHED_EDGE_CNT_EN
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;

    // Free-running modulo count; only RST clears it, stopping does not.
    always_comb begin
        edge_cnt_d = edge_cnt_q + {{(EDGE_W-1){1'b0}}, tick};
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
`else
    // EDGE_W stays in the parameter list so instantiations need not change with the build.
    if (EDGE_W < 1) begin : g_edge_w_unused
    end
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed self-checking bench for clk_div_sched; edge counter checks need CLK_DIV_SCHED_EDGE_CNT_EN.
module tb_clk_div_sched;

    logic       clk_in = 1'b0;
    logic       RST;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_en;
    logic [7:0] cfg_half;
    logic       clk_out;
    logic       tick;
    logic       busy;
    int         checks = 0;
    int         errors = 0;

`ifdef CLK_DIV_SCHED_EDGE_CNT_EN
    logic [15:0] edge_cnt;
    logic [3:0]  edge_cnt4;
    logic        cfg_ready4, clk_out4, tick4, busy4;
`endif

    always #5 clk_in = ~clk_in;

    clk_div_sched #(
        .CNT_W  (8),
        .EDGE_W (16)
    ) dut (
        .clk_in    (clk_in),
        .RST       (RST),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_en    (cfg_en),
        .cfg_half  (cfg_half),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy)
`ifdef CLK_DIV_SCHED_EDGE_CNT_EN
        ,
        .edge_cnt  (edge_cnt)
`endif
    );

`ifdef CLK_DIV_SCHED_EDGE_CNT_EN
    clk_div_sched #(
        .CNT_W  (8),
        .EDGE_W (4)
    ) dut4 (
        .clk_in    (clk_in),
        .RST       (RST),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready4),
        .cfg_en    (cfg_en),
        .cfg_half  (cfg_half),
        .clk_out   (clk_out4),
        .tick      (tick4),
        .busy      (busy4),
        .edge_cnt  (edge_cnt4)
    );
`endif

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_clk_out"}, 0, {15'd0, clk_out}, 16'd0);
        chk({tag, "_tick"}, 0, {15'd0, tick}, 16'd0);
        chk({tag, "_cfg_ready"}, 0, {15'd0, cfg_ready}, 16'd1);
        chk({tag, "_busy"}, 0, {15'd0, busy}, 16'd0);
`ifdef CLK_DIV_SCHED_EDGE_CNT_EN
        chk({tag, "_edge_cnt"}, 0, edge_cnt, 16'd0);
`endif
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        cfg_valid = 1'b0;
        cfg_en    = 1'b0;
        cfg_half  = 8'd0;
        step();
        step();
        chk_reset_outputs("reset");
        RST = 1'b0;
    endtask

    // Present an enabling request during the current cycle (cycle N).
    task automatic start(input logic [7:0] h);
        cfg_valid = 1'b1;
        cfg_en    = 1'b1;
        cfg_half  = h;
    endtask

    // Patterns are MSB-first: bit n-1 is cycle N+1, bit 0 is cycle N+n.
    task automatic run_pat(input string tag, input int n,
                           input logic [31:0] cp, input logic [31:0] tp,
                           input logic [31:0] rp, input logic [31:0] bp,
                           input int req_k, input logic req_en, input logic [7:0] req_half);
        for (int k = 1; k <= n; k++) begin
            step();
            chk({tag, "_clk_out"},   k, {15'd0, clk_out},   {15'd0, cp[n-k]});
            chk({tag, "_tick"},      k, {15'd0, tick},      {15'd0, tp[n-k]});
            chk({tag, "_cfg_ready"}, k, {15'd0, cfg_ready}, {15'd0, rp[n-k]});
            chk({tag, "_busy"},      k, {15'd0, busy},      {15'd0, bp[n-k]});
            $display("tb %s k=%0d clk_out=%0b tick=%0b cfg_ready=%0b busy=%0b",
                     tag, k, clk_out, tick, cfg_ready, busy);
            cfg_valid = (k == req_k);
            cfg_en    = req_en;
            cfg_half  = req_half;
        end
    endtask

    initial begin
        // Reset, then a stop request while idle is absorbed.
        do_reset();
        cfg_valid = 1'b1;
        cfg_en    = 1'b0;
        cfg_half  = 8'd5;
        step();
        cfg_valid = 1'b0;
        chk("idle_stop_busy", 1, {15'd0, busy}, 16'd0);
        chk("idle_stop_clk_out", 1, {15'd0, clk_out}, 16'd0);
        step();
        chk("idle_stop_busy2", 2, {15'd0, busy}, 16'd0);

        // H=3 start: first tick in cycle N+5, 4 high / 4 low.
        start(8'd3);
        run_pat("h3", 16, 32'b0000111100001111, 32'b0000100000001000,
                32'hFFFF, 32'hFFFF, 0, 1'b1, 8'd3);

        // H=0 start: divide by 2.
        do_reset();
        start(8'd0);
        run_pat("h0", 8, 32'b01010101, 32'b01010101, 32'hFF, 32'hFF, 0, 1'b1, 8'd0);

        // H=3 -> H=1 requested mid-high; new half applies from the falling boundary.
        do_reset();
        start(8'd3);
        run_pat("reconf", 16, 32'b0000111100110011, 32'b0000100000100010,
                32'b1111110011111111, 32'hFFFF, 6, 1'b1, 8'd1);

        // Stop request while running H=2.
        do_reset();
        start(8'd2);
        run_pat("stop", 12, 32'b000111000000, 32'b000100000000,
                32'b111110111111, 32'b111111000000, 5, 1'b0, 8'd2);

        // RST while a request is pending.
        do_reset();
        start(8'd3);
        run_pat("pend", 7, 32'b0000111, 32'b0000100, 32'b1111110, 32'b1111111, 6, 1'b1, 8'd1);
        RST       = 1'b1;
        cfg_valid = 1'b0;
        step();
        chk_reset_outputs("pend_rst");
        RST = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("post_rst_clk_out", k, {15'd0, clk_out}, 16'd0);
            chk("post_rst_busy", k, {15'd0, busy}, 16'd0);
        end
        start(8'd3);
        run_pat("restart", 16, 32'b0000111100001111, 32'b0000100000001000,
                32'hFFFF, 32'hFFFF, 0, 1'b1, 8'd3);

`ifdef CLK_DIV_SCHED_EDGE_CNT_EN
        // H=1 ticks land in cycles N+3+4j; the count follows one cycle later.
        do_reset();
        start(8'd1);
        for (int k = 1; k <= 68; k++) begin
            step();
            cfg_valid = 1'b0;
            if (k == 40) begin
                chk("edge_cnt_10", k, edge_cnt, 16'd10);
                chk("edge_cnt4_10", k, {12'd0, edge_cnt4}, 16'd10);
                $display("tb edge k=%0d edge_cnt=%0d edge_cnt4=%0d", k, edge_cnt, edge_cnt4);
            end
        end
        chk("edge_cnt_17", 68, edge_cnt, 16'd17);
        chk("edge_cnt4_wrap", 68, {12'd0, edge_cnt4}, 16'd1);
        $display("tb edge k=68 edge_cnt=%0d edge_cnt4=%0d", edge_cnt, edge_cnt4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
